// File: rtl/square_state_controller.sv
// Per-square health/state machine with an invincibility countdown and an optional colour LFSR.
// Optional feature macro: SQUARE_COLOR_CYCLE_EN (RANDOM_RGB driven by a 12-bit LFSR instead of 12'hFFF).
`ifndef SQUARE_STATE_ENCODE_LENGTH
`define SQUARE_STATE_ENCODE_LENGTH 3
`endif

module square_state_controller #(
   parameter int              INVINCIBLE_TICKS = 60,
   parameter logic [11:0]     LFSR_SEED        = 12'hACE
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic                                   TICK,
   input  logic                                   LOAD,
   input  logic [`SQUARE_STATE_ENCODE_LENGTH-1:0] LOAD_STATE,
   input  logic                                   HIT,
   output logic [`SQUARE_STATE_ENCODE_LENGTH-1:0] COLOR,
   output logic [11:0]                            RANDOM_RGB,
   output logic                                   ALIVE,
   output logic                                   DESTROYED
);

   localparam int CNT_W = $clog2(INVINCIBLE_TICKS + 1);
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(INVINCIBLE_TICKS - 1);

   typedef enum logic [`SQUARE_STATE_ENCODE_LENGTH-1:0] {
      SQUARE_NONE       = 3'd0,
      SQUARE_STRONG     = 3'd1,
      SQUARE_OKAY       = 3'd2,
      SQUARE_WEAK       = 3'd3,
      SQUARE_INVINCIBLE = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] tick_cnt;
   state_t           load_val;

   // Codes 5-7 have no meaning, so a load of one spawns a fresh square.
   always_comb begin
      load_val = SQUARE_STRONG;
      if (LOAD_STATE <= SQUARE_INVINCIBLE)
         load_val = state_t'(LOAD_STATE);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      DESTROYED <= 1'b0;
      if (RST) begin
         state    <= SQUARE_NONE;
         ALIVE    <= 1'b0;
         tick_cnt <= '0;
      end else if (LOAD) begin
         state    <= load_val;
         ALIVE    <= (load_val != SQUARE_NONE);
         tick_cnt <= '0;
      end else begin
         case (state)
            SQUARE_INVINCIBLE: begin
               if (TICK) begin
                  if (tick_cnt == LAST_TICK) begin
                     state    <= SQUARE_STRONG;
                     tick_cnt <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            SQUARE_STRONG: if (HIT) state <= SQUARE_OKAY;
            SQUARE_OKAY:   if (HIT) state <= SQUARE_WEAK;
            SQUARE_WEAK: begin
               if (HIT) begin
                  state     <= SQUARE_NONE;
                  ALIVE     <= 1'b0;
                  DESTROYED <= 1'b1;
               end
            end
            default: tick_cnt <= '0;
         endcase
      end
   end

   assign COLOR = state;

`ifdef SQUARE_COLOR_CYCLE_EN
   logic [11:0] lfsr;

   // Taps 12,6,4,1 give a maximal 4095-state sequence that never visits zero.
   always_ff @(posedge CLK) begin
      if (RST)
         lfsr <= LFSR_SEED;
      else if (!LOAD && TICK && state == SQUARE_INVINCIBLE)
         lfsr <= {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
   end

   assign RANDOM_RGB = lfsr;
`else
   // All ones regardless of the seed; the OR keeps the seed parameter referenced.
   assign RANDOM_RGB = LFSR_SEED | 12'hFFF;
`endif

endmodule

// File: tb/tb_square_state_controller.sv
// Scoreboard bench for square_state_controller: a short-countdown instance for state behaviour
// and a long-countdown instance to walk the full colour sequence.
`timescale 1ns/1ps

module tb_square_state_controller;

   localparam int          TICKS    = 3;
   localparam int          LONG     = 4095;
   localparam logic [11:0] SEED     = 12'hACE;

   typedef struct packed {
      logic [2:0]  color;
      logic        alive;
      logic        destroyed;
      logic [11:0] rgb;
   } obs_t;

   typedef struct packed {
      logic       rst;
      logic       load;
      logic [2:0] ls;
      logic       hit;
      logic       tick;
   } stim_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b0, TICK = 1'b0, LOAD = 1'b0, HIT = 1'b0;
   logic [2:0]  LOAD_STATE = 3'd0;
   logic [2:0]  COLOR;
   logic [11:0] RANDOM_RGB;
   logic        ALIVE, DESTROYED;

   logic        rst2 = 1'b0, tick2 = 1'b0, load2 = 1'b0, hit2 = 1'b0;
   logic [2:0]  ls2 = 3'd0;
   logic [2:0]  color2;
   logic [11:0] rgb2;
   logic        alive2, destroyed2;

   int total = 0;
   int bad   = 0;

   obs_t sb[$];

   int          m_st  = 0;
   int          m_cnt = 0;
   logic        m_des = 1'b0;
   logic [11:0] m_lf  = SEED;

   always #5 CLK = ~CLK;

   square_state_controller #(.INVINCIBLE_TICKS(TICKS), .LFSR_SEED(SEED)) dut (
      .CLK(CLK), .RST(RST), .TICK(TICK), .LOAD(LOAD), .LOAD_STATE(LOAD_STATE), .HIT(HIT),
      .COLOR(COLOR), .RANDOM_RGB(RANDOM_RGB), .ALIVE(ALIVE), .DESTROYED(DESTROYED)
   );

   square_state_controller #(.INVINCIBLE_TICKS(LONG), .LFSR_SEED(SEED)) dut_long (
      .CLK(CLK), .RST(rst2), .TICK(tick2), .LOAD(load2), .LOAD_STATE(ls2), .HIT(hit2),
      .COLOR(color2), .RANDOM_RGB(rgb2), .ALIVE(alive2), .DESTROYED(destroyed2)
   );

   function automatic logic [11:0] lfsr_next(input logic [11:0] r);
      return {r[10:0], r[11] ^ r[5] ^ r[3] ^ r[0]};
   endfunction

   function automatic stim_t mk(input logic rst, input logic load, input logic [2:0] ls,
                                input logic hit, input logic tick);
      stim_t s;
      s.rst = rst; s.load = load; s.ls = ls; s.hit = hit; s.tick = tick;
      return s;
   endfunction

   function automatic logic [11:0] exp_rgb(input logic [11:0] lf);
`ifdef SQUARE_COLOR_CYCLE_EN
      return lf;
`else
      return 12'hFFF;
`endif
   endfunction

   // Drive one cycle on the short instance, advance the reference model and queue its prediction.
   task automatic step(input stim_t s);
      obs_t e;
      RST = s.rst; LOAD = s.load; LOAD_STATE = s.ls; HIT = s.hit; TICK = s.tick;
      m_des = 1'b0;
      if (s.rst) begin
         m_st = 0; m_cnt = 0; m_lf = SEED;
      end else if (s.load) begin
         m_st = (s.ls > 3'd4) ? 1 : int'(s.ls); m_cnt = 0;
      end else begin
         case (m_st)
            4: if (s.tick) begin
                  m_lf = lfsr_next(m_lf);
                  m_cnt++;
                  if (m_cnt == TICKS) begin m_st = 1; m_cnt = 0; end
               end
            1, 2: if (s.hit) m_st++;
            3: if (s.hit) begin m_st = 0; m_des = 1'b1; end
            default: ;
         endcase
      end
      e.color = 3'(m_st); e.alive = (m_st != 0); e.destroyed = m_des; e.rgb = exp_rgb(m_lf);
      sb.push_back(e);
      @(posedge CLK);
      #1;
      RST = 1'b0; LOAD = 1'b0; HIT = 1'b0; TICK = 1'b0; LOAD_STATE = 3'd0;
   endtask

   task automatic test_reset();
      obs_t e, got;
      step(mk(1, 0, 0, 0, 0));
      e = sb.pop_front(); got = '{COLOR, ALIVE, DESTROYED, RANDOM_RGB};
      total++;
      if (got !== e) begin bad++; $display("FAIL reset: got=%h want=%h", got, e); end
      // Reset must win over a simultaneous load, hit and tick.
      step(mk(0, 1, 1, 0, 0));
      step(mk(1, 1, 4, 1, 1));
      void'(sb.pop_front());
      e = sb.pop_front(); got = '{COLOR, ALIVE, DESTROYED, RANDOM_RGB};
      total++;
      if (got !== e) begin bad++; $display("FAIL reset_override: got=%h want=%h", got, e); end
   endtask

   task automatic test_hit_sequence();
      stim_t s [0:6];
      obs_t  e, got;
      s[0] = mk(1, 0, 0, 0, 0); s[1] = mk(0, 1, 1, 0, 0); s[2] = mk(0, 0, 0, 1, 0);
      s[3] = mk(0, 0, 0, 1, 0); s[4] = mk(0, 0, 0, 1, 0); s[5] = mk(0, 0, 0, 0, 0);
      s[6] = mk(0, 0, 0, 1, 1);
      for (int i = 0; i < 7; i++) begin
         step(s[i]);
         e = sb.pop_front(); got = '{COLOR, ALIVE, DESTROYED, RANDOM_RGB};
         total++;
         if (got !== e) begin bad++; $display("FAIL hit_seq[%0d]: got=%h want=%h", i, got, e); end
      end
   endtask

   task automatic test_invincible();
      stim_t s [0:11];
      obs_t  e, got;
      s[0]  = mk(0, 1, 4, 0, 0); s[1]  = mk(0, 0, 0, 1, 0); s[2]  = mk(0, 0, 0, 0, 1);
      s[3]  = mk(0, 0, 0, 1, 0); s[4]  = mk(0, 0, 0, 0, 1); s[5]  = mk(0, 0, 0, 0, 0);
      s[6]  = mk(0, 0, 0, 0, 1); s[7]  = mk(0, 0, 0, 1, 1);
      // Re-arm: a tick that arrives together with the load must not count.
      s[8]  = mk(0, 1, 4, 0, 1); s[9]  = mk(0, 1, 4, 0, 1); s[10] = mk(0, 0, 0, 0, 1);
      s[11] = mk(0, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) begin
         step(s[i]);
         e = sb.pop_front(); got = '{COLOR, ALIVE, DESTROYED, RANDOM_RGB};
         total++;
         if (got !== e) begin bad++; $display("FAIL invincible[%0d]: got=%h want=%h", i, got, e); end
      end
      for (int i = 0; i < 2; i++) begin
         step(mk(0, 0, 0, 0, 1));
         e = sb.pop_front(); got = '{COLOR, ALIVE, DESTROYED, RANDOM_RGB};
         total++;
         if (got !== e) begin bad++; $display("FAIL invincible_end[%0d]: got=%h want=%h", i, got, e); end
      end
   endtask

   task automatic test_load_priority();
      stim_t s [0:5];
      obs_t  e, got;
      s[0] = mk(0, 1, 3, 0, 0); s[1] = mk(0, 1, 2, 1, 0); s[2] = mk(0, 1, 3, 0, 0);
      s[3] = mk(0, 1, 3, 1, 0); s[4] = mk(0, 0, 0, 1, 0); s[5] = mk(0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(s[i]);
         e = sb.pop_front(); got = '{COLOR, ALIVE, DESTROYED, RANDOM_RGB};
         total++;
         if (got !== e) begin bad++; $display("FAIL load_prio[%0d]: got=%h want=%h", i, got, e); end
      end
   endtask

   task automatic test_load_clamp();
      stim_t s [0:5];
      obs_t  e, got;
      s[0] = mk(0, 1, 6, 0, 0); s[1] = mk(0, 1, 0, 0, 0); s[2] = mk(0, 0, 0, 1, 0);
      s[3] = mk(0, 1, 5, 0, 0); s[4] = mk(0, 1, 7, 0, 0); s[5] = mk(0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         step(s[i]);
         e = sb.pop_front(); got = '{COLOR, ALIVE, DESTROYED, RANDOM_RGB};
         total++;
         if (got !== e) begin bad++; $display("FAIL load_clamp[%0d]: got=%h want=%h", i, got, e); end
      end
   endtask

   task automatic test_reset_mid_invincible();
      stim_t s [0:7];
      obs_t  e, got;
      s[0] = mk(0, 1, 4, 0, 0); s[1] = mk(0, 0, 0, 0, 1); s[2] = mk(0, 0, 0, 0, 1);
      s[3] = mk(1, 0, 0, 0, 0); s[4] = mk(0, 1, 4, 0, 0); s[5] = mk(0, 0, 0, 0, 1);
      s[6] = mk(0, 0, 0, 0, 1); s[7] = mk(0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         step(s[i]);
         e = sb.pop_front(); got = '{COLOR, ALIVE, DESTROYED, RANDOM_RGB};
         total++;
         if (got !== e) begin bad++; $display("FAIL reset_mid[%0d]: got=%h want=%h", i, got, e); end
      end
   endtask

   task automatic test_lfsr_period();
      logic [11:0] lf = SEED;
      logic [11:0] want;
      int          errs = 0;
      rst2 = 1'b1;
      @(posedge CLK); #1;
      rst2 = 1'b0; load2 = 1'b1; ls2 = 3'd4;
      @(posedge CLK); #1;
      load2 = 1'b0; ls2 = 3'd0;
      want = exp_rgb(SEED);
      total++;
      if (rgb2 !== want || color2 !== 3'd4) begin
         bad++; $display("FAIL lfsr_start: rgb=%h color=%0d want rgb=%h color=4", rgb2, color2, want);
      end
      for (int i = 1; i <= LONG; i++) begin
         tick2 = 1'b1;
         lf = lfsr_next(lf);
         @(posedge CLK); #1;
         tick2 = 1'b0;
         want = exp_rgb(lf);
         if (rgb2 !== want || rgb2 === 12'h000) begin
            errs++;
            if (errs <= 4) $display("FAIL lfsr_step[%0d]: rgb=%h want=%h", i, rgb2, want);
         end
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL lfsr_walk: errors=%0d want=0", errs); end
      total++;
`ifdef SQUARE_COLOR_CYCLE_EN
      if (rgb2 !== 12'hACE) begin bad++; $display("FAIL lfsr_wrap: rgb=%h want=ace", rgb2); end
`else
      if (rgb2 !== 12'hFFF) begin bad++; $display("FAIL lfsr_const: rgb=%h want=fff", rgb2); end
`endif
      total++;
      if (color2 !== 3'd1) begin bad++; $display("FAIL long_countdown: color=%0d want=1", color2); end
   endtask

   initial begin
      #2;
      test_reset();
      test_hit_sequence();
      test_invincible();
      test_load_priority();
      test_load_clamp();
      test_reset_mid_invincible();
      test_lfsr_period();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
